// File: rtl/timer_multi_pkg.sv
// Shared constants for the multi-channel compare timer: register map, channel
// control field layout and compare-mode encodings.
package timer_multi_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_TIME      = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALER = 8'h04;
    localparam logic [ADDR_W-1:0] ADDR_GCTRL     = 8'h08;
    localparam logic [ADDR_W-1:0] ADDR_IENABLE   = 8'h0C;
    localparam logic [ADDR_W-1:0] ADDR_IPENDING  = 8'h10;
    localparam logic [ADDR_W-1:0] CH_BASE        = 8'h20;
    localparam logic [ADDR_W-1:0] CH_STRIDE      = 8'h10;

    localparam logic [3:0] OFF_CMP    = 4'h0;
    localparam logic [3:0] OFF_PERIOD = 4'h4;
    localparam logic [3:0] OFF_CHCTRL = 4'h8;

    localparam int unsigned GCTRL_RUN_BIT   = 0;
    localparam int unsigned CHCTRL_EN_BIT   = 0;
    localparam int unsigned CHCTRL_MODE_LSB = 1;

    typedef enum logic [1:0] {
        MODE_LEVEL     = 2'b00,
        MODE_ONESHOT   = 2'b01,
        MODE_PERIODIC  = 2'b10,
        MODE_LEVEL_ALT = 2'b11
    } mode_e;

    // Byte address of register 'off' inside channel 'c'.
    function automatic logic [ADDR_W-1:0] ch_addr(input int unsigned c, input logic [3:0] off);
        return ADDR_W'(CH_BASE + CH_STRIDE * ADDR_W'(c)) + {4'b0, off};
    endfunction

endpackage

// File: rtl/timer_multi_if.sv
// Zero-wait peripheral bus between the core and the timer.
interface timer_multi_if;
    import timer_multi_pkg::*;

    logic              cs;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              error;

    modport master (output cs, addr, rw, wdata, input rdata, ready, error);
    modport slave  (input cs, addr, rw, wdata, output rdata, ready, error);
endinterface

// File: rtl/timer_multi_channel.sv
// One compare channel: CMP/PERIOD/CHCTRL, wrap-safe reached detection and the
// per-mode reaction (one-shot disarm, periodic CMP advance).
module timer_multi_channel
    import timer_multi_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  time_i,
    input  logic              sel_i,
    input  logic              we_i,
    input  logic [3:0]        off_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              set_pending_c_o,
    output logic [DATA_W-1:0] rdata_c_o
);

    logic [CNT_W-1:0] cmp_q, cmp_d, period_q, period_d, diff_c;
    logic             en_q, en_d, reached_c;
    mode_e            mode_q, mode_d;
    logic             unused_wdata_c;

    assign unused_wdata_c  = ^wdata_i;
    // TIME at or up to half a range past CMP counts as reached.
    assign diff_c          = time_i - cmp_q;
    assign reached_c       = en_q & ~diff_c[CNT_W-1];
    assign set_pending_c_o = reached_c;

    always_comb begin
        cmp_d    = cmp_q;
        period_d = period_q;
        en_d     = en_q;
        mode_d   = mode_q;
        if (reached_c && mode_q == MODE_PERIODIC) cmp_d = cmp_q + period_q;
        if (reached_c && mode_q == MODE_ONESHOT) en_d = 1'b0;
        // Bus writes override the hardware reaction in the same cycle.
        if (we_i) begin
            case (off_i)
                OFF_CMP:    cmp_d = CNT_W'(wdata_i);
                OFF_PERIOD: period_d = CNT_W'(wdata_i);
                OFF_CHCTRL: begin
                    en_d   = wdata_i[CHCTRL_EN_BIT];
                    mode_d = mode_e'(wdata_i[CHCTRL_MODE_LSB +: 2]);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_q    <= '0;
            period_q <= '0;
            en_q     <= 1'b0;
            mode_q   <= MODE_LEVEL;
        end else begin
            cmp_q    <= cmp_d;
            period_q <= period_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        rdata_c_o = '0;
        if (sel_i) begin
            case (off_i)
                OFF_CMP:    rdata_c_o = DATA_W'(cmp_q);
                OFF_PERIOD: rdata_c_o = DATA_W'(period_q);
                OFF_CHCTRL: rdata_c_o = DATA_W'({mode_q, en_q});
                default:    rdata_c_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/timer_multi.sv
// Free-running TIME counter with tick-enable prescaler, global registers,
// pending/enable interrupt logic and N_CH compare channels behind one bus.
module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PRE_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    timer_multi_if.slave bus,
    output logic         interrupt
);

    logic [CNT_W-1:0]  time_q, time_d;
    logic [PRE_W-1:0]  pre_q, pre_d, pre_cnt_q, pre_cnt_d;
    logic              run_q, run_d;
    logic [N_CH-1:0]   ien_q, ien_d, ipend_q, ipend_d;
    logic [N_CH-1:0]   set_pend_c, ch_we_c;
    logic [DATA_W-1:0] ch_rd_c [N_CH];
    logic [DATA_W-1:0] ch_rdata_c, glob_rdata_c;
    logic [3:0]        ch_idx_c;
    logic              ch_hit_c, glob_hit_c, wr_c, tick_c;

    assign wr_c     = bus.cs & bus.rw;
    assign tick_c   = run_q && (pre_cnt_q == pre_q);
    assign ch_idx_c = bus.addr[7:4] - CH_BASE[7:4];
    assign ch_hit_c = (bus.addr >= CH_BASE) && (32'(ch_idx_c) < N_CH)
                      && (bus.addr[3:0] inside {OFF_CMP, OFF_PERIOD, OFF_CHCTRL});

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic sel_c;
        assign sel_c      = ch_hit_c && (ch_idx_c == 4'(c));
        assign ch_we_c[c] = wr_c && sel_c;
        timer_multi_channel #(.CNT_W(CNT_W)) u_ch (
            .clk             (clk),
            .rst             (rst),
            .time_i          (time_q),
            .sel_i           (sel_c),
            .we_i            (ch_we_c[c]),
            .off_i           (bus.addr[3:0]),
            .wdata_i         (bus.wdata),
            .set_pending_c_o (set_pend_c[c]),
            .rdata_c_o       (ch_rd_c[c])
        );
    end

    // Global register decode and read mux.
    always_comb begin
        glob_hit_c   = 1'b1;
        glob_rdata_c = '0;
        case (bus.addr)
            ADDR_TIME:      glob_rdata_c = DATA_W'(time_q);
            ADDR_PRESCALER: glob_rdata_c = DATA_W'(pre_q);
            ADDR_GCTRL:     glob_rdata_c = DATA_W'(run_q);
            ADDR_IENABLE:   glob_rdata_c = DATA_W'(ien_q);
            ADDR_IPENDING:  glob_rdata_c = DATA_W'(ipend_q);
            default:        glob_hit_c = 1'b0;
        endcase
        ch_rdata_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) ch_rdata_c |= ch_rd_c[i];
    end

    assign bus.rdata = !bus.cs ? '0 : (glob_hit_c ? glob_rdata_c : ch_rdata_c);
    assign bus.error = bus.cs & ~(glob_hit_c | ch_hit_c);
    assign bus.ready = 1'b1;
    assign interrupt = |(ipend_q & ien_q);

    // Hardware pending sets are ORed in after W1C so a same-cycle set wins.
    always_comb begin
        time_d    = time_q;
        pre_d     = pre_q;
        pre_cnt_d = pre_cnt_q;
        run_d     = run_q;
        ien_d     = ien_q;
        ipend_d   = ipend_q | set_pend_c;
        if (run_q) pre_cnt_d = tick_c ? '0 : pre_cnt_q + PRE_W'(1);
        if (tick_c) time_d = time_q + CNT_W'(1);
        if (wr_c) begin
            case (bus.addr)
                ADDR_TIME: time_d = CNT_W'(bus.wdata);
                ADDR_PRESCALER: begin
                    pre_d     = PRE_W'(bus.wdata);
                    pre_cnt_d = '0;
                end
                ADDR_GCTRL: begin
                    run_d = bus.wdata[GCTRL_RUN_BIT];
                    if (!bus.wdata[GCTRL_RUN_BIT]) pre_cnt_d = '0;
                end
                ADDR_IENABLE:  ien_d = N_CH'(bus.wdata);
                ADDR_IPENDING: ipend_d = (ipend_q & ~N_CH'(bus.wdata)) | set_pend_c;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_q    <= '0;
            pre_q     <= '0;
            pre_cnt_q <= '0;
            run_q     <= 1'b0;
            ien_q     <= '0;
            ipend_q   <= '0;
        end else begin
            time_q    <= time_d;
            pre_q     <= pre_d;
            pre_cnt_q <= pre_cnt_d;
            run_q     <= run_d;
            ien_q     <= ien_d;
            ipend_q   <= ipend_d;
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi: reads push expected {rdata,error,irq};
// a negedge monitor pops and compares whenever a check cycle is flagged.
module tb_timer_multi;
    import timer_multi_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        bit          err;
        bit          irq;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic interrupt;
    logic chk;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t cur;

    timer_multi_if bus_if ();

    timer_multi #(.N_CH(4), .CNT_W(32), .PRE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string f, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, f, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty got=none want=entry");
            end else begin
                cur = exp_q.pop_front();
                cmp(cur.name, "rdata", bus_if.rdata, cur.rdata);
                cmp(cur.name, "error", 32'(bus_if.error), 32'(cur.err));
                cmp(cur.name, "irq", 32'(interrupt), 32'(cur.irq));
                cmp(cur.name, "ready", 32'(bus_if.ready), 32'd1);
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus_if.cs    = 1'b1;
        bus_if.rw    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        @(posedge clk);
        #1;
        bus_if.cs = 1'b0;
        bus_if.rw = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] er,
                      input bit ee, input bit ei, input bit cs_v = 1'b1);
        bus_if.cs   = cs_v;
        bus_if.rw   = 1'b0;
        bus_if.addr = a;
        chk         = 1'b1;
        exp_q.push_back('{nm, er, ee, ei});
        @(posedge clk);
        #1;
        bus_if.cs = 1'b0;
        chk       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        chk = 1'b0;
        bus_if.cs = 1'b0; bus_if.rw = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // reset state
        rd("rst_time", ADDR_TIME, 0, 0, 0);
        rd("rst_pre", ADDR_PRESCALER, 0, 0, 0);
        rd("rst_gctrl", ADDR_GCTRL, 0, 0, 0);
        rd("rst_ien", ADDR_IENABLE, 0, 0, 0);
        rd("rst_ipend", ADDR_IPENDING, 0, 0, 0);
        rd("rst_cmp0", ch_addr(0, OFF_CMP), 0, 0, 0);
        rd("rst_ctl3", ch_addr(3, OFF_CHCTRL), 0, 0, 0);

        // prescaler 3: one TIME step every 4 clocks
        wr(ADDR_PRESCALER, 3);
        wr(ADDR_GCTRL, 1);
        idle(40);
        rd("pre_time10", ADDR_TIME, 10, 0, 0);
        rd("pre_gctrl", ADDR_GCTRL, 1, 0, 0);
        rd("pre_reg", ADDR_PRESCALER, 3, 0, 0);
        wr(ADDR_GCTRL, 0);
        wr(ADDR_TIME, 32'hFFFF_FFFE);
        rd("wrap_load", ADDR_TIME, 32'hFFFF_FFFE, 0, 0);
        wr(ADDR_PRESCALER, 3);
        wr(ADDR_GCTRL, 1);
        idle(4);
        rd("wrap_1", ADDR_TIME, 32'hFFFF_FFFF, 0, 0);
        idle(3);
        rd("wrap_0", ADDR_TIME, 0, 0, 0);

        // one-shot on ch0
        wr(ADDR_GCTRL, 0);
        wr(ADDR_PRESCALER, 0);
        wr(ADDR_TIME, 0);
        wr(ch_addr(0, OFF_CMP), 20);
        wr(ADDR_IENABLE, 1);
        wr(ch_addr(0, OFF_CHCTRL), 3);
        wr(ADDR_GCTRL, 1);
        idle(20);
        rd("os_at20", ADDR_IPENDING, 0, 0, 0);
        rd("os_set", ADDR_IPENDING, 1, 0, 1);
        rd("os_en_clr", ch_addr(0, OFF_CHCTRL), 2, 0, 1);
        rd("os_time", ADDR_TIME, 23, 0, 1);
        wr(ADDR_IPENDING, 1);
        rd("os_w1c", ADDR_IPENDING, 0, 0, 0);
        idle(5);
        rd("os_stays", ADDR_IPENDING, 0, 0, 0);

        // periodic on ch1 across the TIME wrap
        wr(ADDR_GCTRL, 0);
        wr(ADDR_TIME, 32'hFFFF_FFF0);
        wr(ch_addr(1, OFF_CMP), 32'hFFFF_FFF8);
        wr(ch_addr(1, OFF_PERIOD), 32'h10);
        wr(ADDR_IENABLE, 2);
        wr(ch_addr(1, OFF_CHCTRL), 5);
        wr(ADDR_GCTRL, 1);
        idle(8);
        rd("per_before", ADDR_IPENDING, 0, 0, 0);
        rd("per_set", ADDR_IPENDING, 2, 0, 1);
        rd("per_cmp8", ch_addr(1, OFF_CMP), 8, 0, 1);
        wr(ADDR_IPENDING, 2);
        rd("per_clr", ADDR_IPENDING, 0, 0, 0);
        rd("per_period", ch_addr(1, OFF_PERIOD), 32'h10, 0, 0);
        idle(9);
        rd("per_quiet", ADDR_IPENDING, 0, 0, 0);
        rd("per_time8", ADDR_TIME, 8, 0, 0);
        rd("per_set2", ADDR_IPENDING, 2, 0, 1);
        rd("per_cmp18", ch_addr(1, OFF_CMP), 32'h18, 0, 1);
        wr(ADDR_GCTRL, 0);
        wr(ch_addr(1, OFF_CHCTRL), 0);
        wr(ADDR_IPENDING, 2);
        rd("per_off", ADDR_IPENDING, 0, 0, 0);

        // level mode on ch2: W1C does not stick
        wr(ADDR_TIME, 32'h100);
        wr(ch_addr(2, OFF_CMP), 32'h50);
        wr(ch_addr(2, OFF_CHCTRL), 1);
        wr(ADDR_IPENDING, 4);
        rd("lvl_race", ADDR_IPENDING, 4, 0, 0);
        wr(ADDR_IPENDING, 4);
        rd("lvl_resets", ADDR_IPENDING, 4, 0, 0);
        wr(ch_addr(2, OFF_CHCTRL), 0);
        wr(ADDR_IPENDING, 4);
        rd("lvl_off", ADDR_IPENDING, 0, 0, 0);

        // one-shot set on ch3 coincides with W1C of the same bit
        wr(ch_addr(3, OFF_CMP), 32'h100);
        wr(ch_addr(3, OFF_CHCTRL), 3);
        wr(ADDR_IPENDING, 8);
        rd("os_race", ADDR_IPENDING, 8, 0, 0);
        rd("os_race_en", ch_addr(3, OFF_CHCTRL), 2, 0, 0);
        wr(ADDR_IPENDING, 8);
        rd("os_race_clr", ADDR_IPENDING, 0, 0, 0);

        // masking with all channels pending in level mode (ch3 uses MODE=11)
        wr(ADDR_IENABLE, 0);
        wr(ch_addr(0, OFF_CHCTRL), 1);
        wr(ch_addr(1, OFF_CHCTRL), 1);
        wr(ch_addr(2, OFF_CHCTRL), 1);
        wr(ch_addr(3, OFF_CHCTRL), 7);
        idle(1);
        rd("mask_all", ADDR_IPENDING, 32'hF, 0, 0);
        wr(ADDR_IENABLE, 4);
        rd("mask_en4", ADDR_IPENDING, 32'hF, 0, 1);
        rd("mask_ien", ADDR_IENABLE, 4, 0, 1);
        wr(ADDR_IPENDING, 32'hF);
        rd("mask_lvl", ADDR_IPENDING, 32'hF, 0, 1);

        // bus errors and cs gating
        rd("err_2c", 8'h2C, 0, 1, 1);
        rd("err_84", 8'h84, 0, 1, 1);
        rd("err_14", 8'h14, 0, 1, 1);
        rd("err_0d", 8'h0D, 0, 1, 1);
        rd("nocs_2c", 8'h2C, 0, 0, 1, 1'b0);
        rd("nocs_time", ADDR_TIME, 0, 0, 1, 1'b0);
        wr(8'h84, 32'hFFFF_FFFF);
        rd("err_wr_ign", ch_addr(0, OFF_CHCTRL), 1, 0, 1);

        idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
